frame_classifier: RTL
=====================

Name: frame_classifier

Overview:
- Parametrised successor to the single-channel RX frame splitter.
- Parses the byte-stream Ethernet RX path and checks MAC, EtherType, IPv4 header and UDP destination port.
- Routes each frame's payload to one of three AXI-stream-style byte outputs: ARP, ICMP, or UDP. The UDP output is shared by NUM_UDP_CH logical channels, selected by destination port.
- Non-matching frames are consumed and counted. Sits between the MAC RX FIFO and the ARP, ICMP and UDP engines.

Parameters:
LOCAL_IP, 32'hC0A8_006E, local IPv4 address
LOCAL_MAC, 48'hABCD_1234_5678, local MAC address
NUM_UDP_CH, 4, number of UDP logical channels (1..16)
UDP_PORT_BASE, 16'd8000, channel k accepts dst port UDP_PORT_BASE+k
CNT_W, 16, width of drop/frame counters

Ports:
logic_clk  in  1  clock
logic_rst  in  1  reset, asynchronous, active-high
net_rdata_in  in  8  RX byte
net_rvalid_in  in  1  RX byte valid
net_rready_out  out  1  RX byte accepted when valid&ready
net_rlast_in  in  1  last byte of frame
arp_rdata_out/arp_rvalid_out/arp_rlast_out  out  8/1/1  ARP body (after Ethernet header)
arp_rready_in  in  1  ARP sink ready
icmp_rdata_out/icmp_rvalid_out/icmp_rlast_out  out  8/1/1  ICMP message (after IP header)
icmp_rready_in  in  1
icmp_src_ip_out  out  32  source IP, stable while ICMP data is valid
udp_rdata_out/udp_rvalid_out/udp_rlast_out  out  8/1/1  UDP payload
udp_rready_in  in  1
udp_chan_out  out  $clog2(NUM_UDP_CH) (min 1)  channel index
udp_src_ip_out  out  32  source IP
udp_src_port_out  out  16  source port
udp_len_out  out  16  payload length (UDP length field − 8)
drop_cnt_out  out  CNT_W  frames discarded, wraps
frame_cnt_out  out  CNT_W  frames delivered to any sink, wraps

Behaviour:
- Reset:
  - State IDLE; all valid/last/ready outputs 0.
  - Metadata and counters 0.
  - Asserting reset mid-frame aborts the frame. After release the block resynchronises: every byte up to the next rlast is dropped and counted once.
- States: IDLE, ETH_HEAD, IP_HEAD, UDP_HEAD, ARP_DATA, ICMP_DATA, UDP_DATA, DROP.
- Header states:
  - net_rready_out=1; bytes counted only on valid&ready.
  - IDLE → ETH_HEAD on first valid (byte 0 is consumed in ETH_HEAD).
- ETH_HEAD (14 bytes): bytes 0–5 dst MAC, 12–13 EtherType. On the 14th accepted byte:
  - dst MAC ≠ LOCAL_MAC and ≠ all-ones → DROP;
  - type 0x0806 → ARP_DATA;
  - type 0x0800 → IP_HEAD;
  - else → DROP.
- IP_HEAD (20 bytes):
  - byte 0 must be 0x45 (IHL≠5 or version≠4 → DROP); byte 9 = protocol; bytes 12–15 src IP; 16–19 dst IP.
  - At byte 20: dst IP ≠ LOCAL_IP → DROP; proto 0x01 → ICMP_DATA; proto 0x11 → UDP_HEAD; else → DROP.
- UDP_HEAD (8 bytes): bytes 0–1 src port, 2–3 dst port, 4–5 length.
  - At byte 8: dst port − UDP_PORT_BASE < NUM_UDP_CH (unsigned) → UDP_DATA with udp_chan_out latched; else → DROP.
  - UDP length < 8 → DROP.
- Metadata outputs are registered on the transition into the DATA state and held until the next transition into that state.
- DATA states: zero-latency pass-through.
  - out_rdata=net_rdata_in; out_rvalid=net_rvalid_in; out_rlast=net_rlast_in; net_rready_out=out_rready_in.
  - Leave to IDLE on an accepted byte with rlast; frame_cnt +1 at that byte.
  - Other outputs' valid stays 0.
- DROP: net_rready_out=1. On accepted rlast → IDLE; drop_cnt +1.
- rlast accepted in any header state (runt frame) → IDLE; drop_cnt +1. Nothing is emitted to any sink.
- Back-to-back frames: a byte following rlast in the same cycle as the IDLE return starts a new frame. No dead cycle is required beyond the IDLE state.
- The UDP output carries all bytes up to input rlast; the Ethernet FCS/padding has already been stripped upstream. udp_len_out is informational only.

Decomposition:
- Package eth_pkg: GLOBAL_MAC, ARP_TYPE, IP_TYPE, ICMP_PROTO, UDP_PROTO, ETH/IP/UDP header lengths, and the split-state enum typedef.
- Optional sub-module hdr_field_capture: byte counter plus field shift-register, reused per header state. A single module is otherwise acceptable.

Test Plan:
1. Broadcast ARP frame (dst FF..FF, type 0x0806, 28-byte body) → 28 bytes on ARP output, last on byte 28; frame_cnt=1; icmp/udp valid stay 0.
2. UDP to 192.168.0.110 port 8001, src 192.168.0.5:1234, length 0x000C, 4 payload bytes, udp_rready toggling every cycle → udp_chan_out=1, src ip/port correct, udp_len_out=4. Payload is delivered intact with no loss or duplication; net_rready_out mirrors udp_rready_in.
3. IPv4 frame to dst MAC 11:22:33:44:55:66 → fully consumed, no sink valid, drop_cnt=1.
4. IP byte 0 = 0x46 (IHL=6) → DROP, drop_cnt +1. Also UDP dst port 8004 with NUM_UDP_CH=4 → DROP.
5. ICMP echo request (proto 1, 40-byte message) followed back-to-back by a 10-byte runt → 40 bytes on ICMP with icmp_src_ip_out set; runt dropped; drop_cnt +1, frame_cnt +1.
6. Assert logic_rst asynchronously mid-UDP payload → outputs 0 immediately. Remainder of the frame is dropped (drop_cnt=1), and the next frame is classified correctly.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared constants and state type for the Ethernet RX frame classifier.
package eth_pkg;

    localparam logic [47:0] GLOBAL_MAC = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] ARP_TYPE   = 16'h0806;
    localparam logic [15:0] IP_TYPE    = 16'h0800;
    localparam logic [7:0]  ICMP_PROTO = 8'h01;
    localparam logic [7:0]  UDP_PROTO  = 8'h11;
    localparam logic [7:0]  IPV4_VIHL  = 8'h45;

    localparam int unsigned ETH_HDR_LEN = 14;
    localparam int unsigned IP_HDR_LEN  = 20;
    localparam int unsigned UDP_HDR_LEN = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ETH_HEAD,
        ST_IP_HEAD,
        ST_UDP_HEAD,
        ST_ARP_DATA,
        ST_ICMP_DATA,
        ST_UDP_DATA,
        ST_DROP
    } split_state_t;

endpackage

// File: rtl/frame_classifier_hdr_field_capture.sv
// Header byte counter plus a shift register exposing the last eight bytes
// (including the byte currently presented) as one big-endian word.
module hdr_field_capture (
    input  logic        logic_clk,
    input  logic        logic_rst,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  data,
    output logic [4:0]  idx,
    output logic [63:0] word
);

    logic [4:0]  cnt;
    logic [55:0] sh;

    always_ff @(posedge logic_clk or posedge logic_rst) begin
        if (logic_rst) begin
            cnt <= '0;
            sh  <= '0;
        end else begin
            if (clear)
                cnt <= '0;
            else if (take)
                cnt <= cnt + 5'd1;
            if (take)
                sh <= {sh[47:0], data};
        end
    end

    assign idx  = cnt;
    assign word = {sh, data};

endmodule

// File: rtl/frame_classifier.sv
// RX frame splitter: parses Ethernet/IPv4/UDP headers and routes each frame's
// payload to the ARP, ICMP or UDP sink; everything else is consumed and counted.
module frame_classifier
    import eth_pkg::*;
#(
    parameter logic [31:0] LOCAL_IP      = 32'hC0A8_006E,
    parameter logic [47:0] LOCAL_MAC     = 48'hABCD_1234_5678,
    parameter int unsigned NUM_UDP_CH    = 4,
    parameter logic [15:0] UDP_PORT_BASE = 16'd8000,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                   logic_clk,
    input  logic                   logic_rst,
    input  logic [7:0]             net_rdata_in,
    input  logic                   net_rvalid_in,
    output logic                   net_rready_out,
    input  logic                   net_rlast_in,
    output logic [7:0]             arp_rdata_out,
    output logic                   arp_rvalid_out,
    output logic                   arp_rlast_out,
    input  logic                   arp_rready_in,
    output logic [7:0]             icmp_rdata_out,
    output logic                   icmp_rvalid_out,
    output logic                   icmp_rlast_out,
    input  logic                   icmp_rready_in,
    output logic [31:0]            icmp_src_ip_out,
    output logic [7:0]             udp_rdata_out,
    output logic                   udp_rvalid_out,
    output logic                   udp_rlast_out,
    input  logic                   udp_rready_in,
    output logic [((NUM_UDP_CH > 1) ? $clog2(NUM_UDP_CH) : 1)-1:0] udp_chan_out,
    output logic [31:0]            udp_src_ip_out,
    output logic [15:0]            udp_src_port_out,
    output logic [15:0]            udp_len_out,
    output logic [CNT_W-1:0]       drop_cnt_out,
    output logic [CNT_W-1:0]       frame_cnt_out
);

    localparam int unsigned CHW = (NUM_UDP_CH > 1) ? $clog2(NUM_UDP_CH) : 1;

    split_state_t state, state_n;
    logic         resync, mac_ok;
    logic [7:0]   proto;
    logic [31:0]  src_ip;
    logic [4:0]   idx;
    logic [63:0]  word;
    logic [15:0]  chan_off;
    logic         chan_ok, acc, hdr, data_st, take, clear, frame_done, drop_done;

    hdr_field_capture u_cap (
        .logic_clk (logic_clk),
        .logic_rst (logic_rst),
        .clear     (clear),
        .take      (take),
        .data      (net_rdata_in),
        .idx       (idx),
        .word      (word)
    );

    assign chan_off = word[47:32] - UDP_PORT_BASE;
    assign chan_ok  = chan_off < 16'(NUM_UDP_CH);

    assign arp_rdata_out  = net_rdata_in;
    assign icmp_rdata_out = net_rdata_in;
    assign udp_rdata_out  = net_rdata_in;

    always_comb begin
        state_n         = state;
        net_rready_out  = 1'b0;
        arp_rvalid_out  = 1'b0;
        arp_rlast_out   = 1'b0;
        icmp_rvalid_out = 1'b0;
        icmp_rlast_out  = 1'b0;
        udp_rvalid_out  = 1'b0;
        udp_rlast_out   = 1'b0;
        frame_done      = 1'b0;
        drop_done       = 1'b0;
        hdr             = state inside {ST_ETH_HEAD, ST_IP_HEAD, ST_UDP_HEAD};
        data_st         = state inside {ST_ARP_DATA, ST_ICMP_DATA, ST_UDP_DATA};

        case (state)
            // After reset the line position is unknown, so the first frame is discarded.
            ST_IDLE: if (net_rvalid_in) state_n = resync ? ST_DROP : ST_ETH_HEAD;
            ST_ETH_HEAD, ST_IP_HEAD, ST_UDP_HEAD, ST_DROP: net_rready_out = 1'b1;
            ST_ARP_DATA: begin
                net_rready_out = arp_rready_in;
                arp_rvalid_out = net_rvalid_in;
                arp_rlast_out  = net_rlast_in;
            end
            ST_ICMP_DATA: begin
                net_rready_out  = icmp_rready_in;
                icmp_rvalid_out = net_rvalid_in;
                icmp_rlast_out  = net_rlast_in;
            end
            ST_UDP_DATA: begin
                net_rready_out = udp_rready_in;
                udp_rvalid_out = net_rvalid_in;
                udp_rlast_out  = net_rlast_in;
            end
            default: state_n = ST_IDLE;
        endcase

        acc  = net_rvalid_in && net_rready_out;
        take = acc && hdr;

        if (acc) begin
            if (net_rlast_in) begin
                state_n    = ST_IDLE;
                frame_done = data_st;
                drop_done  = !data_st;
            end else begin
                case (state)
                    ST_ETH_HEAD: if (idx == 5'(ETH_HDR_LEN - 1)) begin
                        if (!mac_ok)                  state_n = ST_DROP;
                        else if (word[15:0] == ARP_TYPE) state_n = ST_ARP_DATA;
                        else if (word[15:0] == IP_TYPE)  state_n = ST_IP_HEAD;
                        else                          state_n = ST_DROP;
                    end
                    ST_IP_HEAD: begin
                        if (idx == 5'd0 && net_rdata_in != IPV4_VIHL)
                            state_n = ST_DROP;
                        else if (idx == 5'(IP_HDR_LEN - 1)) begin
                            if (word[31:0] != LOCAL_IP)   state_n = ST_DROP;
                            else if (proto == ICMP_PROTO) state_n = ST_ICMP_DATA;
                            else if (proto == UDP_PROTO)  state_n = ST_UDP_HEAD;
                            else                          state_n = ST_DROP;
                        end
                    end
                    ST_UDP_HEAD: if (idx == 5'(UDP_HDR_LEN - 1))
                        state_n = (chan_ok && word[31:16] >= 16'(UDP_HDR_LEN)) ? ST_UDP_DATA : ST_DROP;
                    default: ;
                endcase
            end
        end

        clear = (state_n != state);
    end

    always_ff @(posedge logic_clk or posedge logic_rst) begin
        if (logic_rst) begin
            state            <= ST_IDLE;
            resync           <= 1'b1;
            mac_ok           <= 1'b0;
            proto            <= '0;
            src_ip           <= '0;
            icmp_src_ip_out  <= '0;
            udp_chan_out     <= '0;
            udp_src_ip_out   <= '0;
            udp_src_port_out <= '0;
            udp_len_out      <= '0;
            drop_cnt_out     <= '0;
            frame_cnt_out    <= '0;
        end else begin
            state <= state_n;
            if (state == ST_IDLE && net_rvalid_in)
                resync <= 1'b0;
            if (take && state == ST_ETH_HEAD && idx == 5'd5)
                mac_ok <= (word[47:0] == LOCAL_MAC) || (word[47:0] == GLOBAL_MAC);
            if (take && state == ST_IP_HEAD && idx == 5'd9)
                proto <= net_rdata_in;
            if (take && state == ST_IP_HEAD && idx == 5'd15)
                src_ip <= word[31:0];
            if (state_n == ST_ICMP_DATA && state != ST_ICMP_DATA)
                icmp_src_ip_out <= src_ip;
            if (state_n == ST_UDP_DATA && state != ST_UDP_DATA) begin
                udp_chan_out     <= chan_off[CHW-1:0];
                udp_src_ip_out   <= src_ip;
                udp_src_port_out <= word[63:48];
                udp_len_out      <= word[31:16] - 16'(UDP_HDR_LEN);
            end
            if (drop_done)
                drop_cnt_out <= drop_cnt_out + CNT_W'(1);
            if (frame_done)
                frame_cnt_out <= frame_cnt_out + CNT_W'(1);
        end
    end

endmodule
